// File: rtl/crosshair_pkg.sv
// Shared encodings for the crosshair overlay generator: shape modes and timing-tracker states.
package crosshair_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_CROSS = 2'd1;
  localparam logic [1:0] MODE_BOX   = 2'd2;
  localparam logic [1:0] MODE_DOT   = 2'd3;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    VBLANK  = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an active-low sync input plus a registered falling-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic fall_pulse
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Idle level of the sync lines is high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg   <= 1'b1;
      sync_reg   <= 1'b1;
      prev_reg   <= 1'b1;
      fall_pulse <= 1'b0;
    end else begin
      meta_reg   <= async_in;
      sync_reg   <= meta_reg;
      prev_reg   <= sync_reg;
      fall_pulse <= prev_reg & ~sync_reg;
    end
  end

endmodule

// File: rtl/crosshair_overlay_gen.sv
// Crosshair / box / dot overlay gate generator locked to separated vsync/csync on the pixel clock.
// Build option: define CROSSHAIR_OUTLINE_EN to drive gate_b with a one-pixel black border.
module crosshair_overlay_gen
  import crosshair_pkg::*;
#(
  parameter int XW           = 9,
  parameter int YW           = 9,
  parameter int H_START      = 44,
  parameter int V_START      = 20,
  parameter int ARM          = 16,
  parameter int THICK        = 2,
  parameter int HOLDOFF      = 160,
  parameter int LINE_TIMEOUT = 320
) (
  input  logic          clk4mhz,
  input  logic          rst,
  input  logic          vsync,
  input  logic          csync,
  input  logic [1:0]    mode,
  input  logic [XW-1:0] centre_x,
  input  logic [YW-1:0] centre_y,
  output logic          gate_w,
  output logic          gate_b,
  output logic          locked,
  output logic          frame_tick
);

  localparam int HW = $clog2(LINE_TIMEOUT + 1);
  localparam int VW = YW + 1;

  logic          vs_fall;
  logic          cs_fall;
  state_t        state_reg, state_next;
  logic [HW-1:0] hcnt_reg, hcnt_next;
  logic [VW-1:0] vcnt_reg, vcnt_next;
  logic [1:0]    mode_reg;
  logic [XW-1:0] cx_reg;
  logic [YW-1:0] cy_reg;
  logic          line_start;
  logic          timeout;
  logic          pix_valid;
  logic          hit;
  int            x_pos, y_pos, dx, dy;

  sync_edge_detect u_vs_sync (.clk(clk4mhz), .rst(rst), .async_in(vsync), .fall_pulse(vs_fall));
  sync_edge_detect u_cs_sync (.clk(clk4mhz), .rst(rst), .async_in(csync), .fall_pulse(cs_fall));

  // Strokes occupy [lo, lo+thick) from the centre; the expanded shape reuses this with a wider band.
  function automatic logic shape_hit(input logic [1:0] m, input int ddx, input int ddy,
                                     input int arm, input int thick, input int lo);
    int adx, ady;
    adx = (ddx < 0) ? -ddx : ddx;
    ady = (ddy < 0) ? -ddy : ddy;
    case (m)
      MODE_CROSS: shape_hit = ((ddy >= lo) && (ddy < lo + thick) && (adx <= arm)) ||
                              ((ddx >= lo) && (ddx < lo + thick) && (ady <= arm));
      MODE_BOX:   shape_hit = (adx <= arm) && (ady <= arm) &&
                              ((adx > arm - thick) || (ady > arm - thick));
      MODE_DOT:   shape_hit = (ddx >= lo) && (ddx < lo + thick) &&
                              (ddy >= lo) && (ddy < lo + thick);
      default:    shape_hit = 1'b0;
    endcase
  endfunction

  // Equalising pulses fall mid-line; only edges past the holdoff count as new lines once locked.
  always_comb begin
    line_start = cs_fall && ((hcnt_reg >= HW'(HOLDOFF)) || (state_reg == WAIT_VS));
    timeout    = (hcnt_reg == HW'(LINE_TIMEOUT));
    hcnt_next  = hcnt_reg;
    if (line_start)
      hcnt_next = '0;
    else if (!timeout)
      hcnt_next = hcnt_reg + 1'b1;
    vcnt_next = vcnt_reg;
    if (vs_fall)
      vcnt_next = '0;
    else if (line_start && (vcnt_reg != '1))
      vcnt_next = vcnt_reg + 1'b1;
  end

  always_ff @(posedge clk4mhz or posedge rst) begin
    if (rst) begin
      hcnt_reg   <= '0;
      vcnt_reg   <= '0;
      mode_reg   <= MODE_OFF;
      cx_reg     <= '0;
      cy_reg     <= '0;
      frame_tick <= 1'b0;
    end else begin
      hcnt_reg   <= hcnt_next;
      vcnt_reg   <= vcnt_next;
      frame_tick <= vs_fall;
      if (vs_fall) begin
        mode_reg <= mode;
        cx_reg   <= centre_x;
        cy_reg   <= centre_y;
      end
    end
  end

  always_ff @(posedge clk4mhz or posedge rst) begin
    if (rst)
      state_reg <= WAIT_VS;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_VS: if (vs_fall) state_next = VBLANK;
      VBLANK: begin
        if (timeout)                            state_next = WAIT_VS;
        else if (vs_fall)                       state_next = VBLANK;
        else if (vcnt_reg == VW'(V_START))      state_next = ACTIVE;
      end
      ACTIVE: begin
        if (timeout)      state_next = WAIT_VS;
        else if (vs_fall) state_next = VBLANK;
      end
      default: state_next = WAIT_VS;
    endcase
  end

  always_comb begin
    locked    = (state_reg != WAIT_VS);
    x_pos     = int'(hcnt_reg) - H_START;
    y_pos     = int'(vcnt_reg) - V_START;
    pix_valid = (state_reg == ACTIVE) && (x_pos >= 0) && (x_pos < (1 << XW)) &&
                (y_pos >= 0) && (y_pos < (1 << YW));
    dx        = x_pos - int'(cx_reg);
    dy        = y_pos - int'(cy_reg);
    hit       = pix_valid && shape_hit(mode_reg, dx, dy, ARM, THICK, 0);
  end

  always_ff @(posedge clk4mhz or posedge rst) begin
    if (rst)
      gate_w <= 1'b0;
    else
      gate_w <= hit;
  end

`ifdef CROSSHAIR_OUTLINE_EN
  // Border = shape grown by one pixel on every side, minus the shape itself.
  always_ff @(posedge clk4mhz or posedge rst) begin
    if (rst)
      gate_b <= 1'b0;
    else
      gate_b <= pix_valid && !hit && shape_hit(mode_reg, dx, dy, ARM + 1, THICK + 2, -1);
  end
`else
  assign gate_b = 1'b0;
`endif

endmodule

// File: tb/tb_crosshair_overlay_gen.sv
// Self-checking bench: synthetic 256-clock lines, per-cycle check of gates/locked/frame_tick against a shape model.
`timescale 1ns/1ps
module tb_crosshair_overlay_gen;

  localparam int XW = 9, YW = 9, H_START = 44, V_START = 20, ARM = 16, THICK = 2;
  localparam int LINE_CLKS = 256, SYNC_W = 19, EQ_AT = 128, EQ_W = 9, EQ_LINES = 6, VS_LINES = 3;
  localparam int PIX_LAT  = H_START + 4;  // x=0 visible this many edges after the edge sampling the csync fall
  localparam int TICK_LAT = 3;

  logic          clk4mhz  = 1'b0;
  logic          rst      = 1'b1;
  logic          vsync    = 1'b1;
  logic          csync    = 1'b1;
  logic [1:0]    mode     = 2'd1;
  logic [XW-1:0] centre_x = 9'd100;
  logic [YW-1:0] centre_y = 9'd50;
  logic          gate_w, gate_b, locked, frame_tick;

  int vectors = 0, miscompares = 0, cyc = 0, frame_no = 0;
  int sh_mode = 0, sh_cx = 0, sh_cy = 0;

  crosshair_overlay_gen #(
    .XW(XW), .YW(YW), .H_START(H_START), .V_START(V_START), .ARM(ARM), .THICK(THICK),
    .HOLDOFF(160), .LINE_TIMEOUT(320)
  ) dut (
    .clk4mhz(clk4mhz), .rst(rst), .vsync(vsync), .csync(csync), .mode(mode),
    .centre_x(centre_x), .centre_y(centre_y), .gate_w(gate_w), .gate_b(gate_b),
    .locked(locked), .frame_tick(frame_tick)
  );

  always #125 clk4mhz = ~clk4mhz;

  task automatic check_eq(input string tag, input logic actual, input logic expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", tag, cyc, actual, expected);
    end
  endtask

  function automatic bit in_rect(input int x, input int y, input int x0, input int x1,
                                 input int y0, input int y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  // Shapes as unions/differences of rectangles; g grows every rectangle edge outward (box hole shrinks).
  function automatic bit shape_px(input int m, input int cx, input int cy, input int x, input int y,
                                  input int g);
    case (m)
      1: return in_rect(x, y, cx - ARM - g, cx + ARM + g, cy - g, cy + THICK - 1 + g) ||
                in_rect(x, y, cx - g, cx + THICK - 1 + g, cy - ARM - g, cy + ARM + g);
      2: return in_rect(x, y, cx - ARM - g, cx + ARM + g, cy - ARM - g, cy + ARM + g) &&
                !in_rect(x, y, cx - ARM + THICK + g, cx + ARM - THICK - g,
                         cy - ARM + THICK + g, cy + ARM - THICK - g);
      3: return in_rect(x, y, cx - g, cx + THICK - 1 + g, cy - g, cy + THICK - 1 + g);
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input logic cs, input logic vs, input int px, input int py,
                      input bit chk_lock, input bit exp_lock, input bit exp_tick);
    bit ew, eb;
    @(negedge clk4mhz);
    csync = cs;
    vsync = vs;
    @(posedge clk4mhz);
    #1;
    cyc++;
    ew = 1'b0;
    eb = 1'b0;
    if (px >= 0 && py >= 0) begin
      ew = shape_px(sh_mode, sh_cx, sh_cy, px, py, 0);
`ifdef CROSSHAIR_OUTLINE_EN
      eb = shape_px(sh_mode, sh_cx, sh_cy, px, py, 1) && !ew;
`endif
    end
    check_eq("gate_w", gate_w, ew);
    check_eq("gate_b", gate_b, eb);
    check_eq("frame_tick", frame_tick, exp_tick);
    if (chk_lock) check_eq("locked", locked, exp_lock);
  endtask

  task automatic run_line(input int l, input bit in_frame, input bit first);
    logic cs, vs;
    bit lk, tk;
    for (int c = 0; c < LINE_CLKS; c++) begin
      cs = !((c < SYNC_W) || (in_frame && l < EQ_LINES && c >= EQ_AT && c < EQ_AT + EQ_W));
      vs = !(in_frame && l < VS_LINES);
      lk = in_frame && !(first && l == 0 && c < TICK_LAT);
      tk = in_frame && l == 0 && c == TICK_LAT;
      step(cs, vs, c - PIX_LAT, in_frame ? l - V_START : -1, 1'b1, lk, tk);
    end
  endtask

  // Config presented at the vsync fall governs the frame; scrambled inputs afterwards must not leak in.
  task automatic run_frame(input int lines, input bit first, input int nm, input int ncx, input int ncy);
    sh_mode = int'(mode);
    sh_cx   = int'(centre_x);
    sh_cy   = int'(centre_y);
    frame_no++;
    $display("frame %0d: mode=%0d centre=(%0d,%0d) lines=%0d", frame_no, sh_mode, sh_cx, sh_cy, lines);
    for (int l = 0; l < lines; l++) begin
      if (l == VS_LINES) begin
        mode     = 2'($urandom_range(0, 3));
        centre_x = XW'($urandom);
        centre_y = YW'($urandom);
      end
      if (l == lines / 2) begin
        mode     = 2'(nm);
        centre_x = XW'(ncx);
        centre_y = YW'(ncy);
      end
      run_line(l, 1'b1, first);
    end
  endtask

  initial begin
    logic rc, rv;
    // Reset held with sync lines toggling: everything stays low.
    for (int i = 0; i < 40; i++) begin
      rc = (i < 35) ? 1'($urandom) : 1'b1;
      rv = (i < 35) ? 1'($urandom) : 1'b1;
      step(rc, rv, -1, -1, 1'b1, 1'b0, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
    // Lines before any vsync: no lock, no gates.
    for (int l = 0; l < 3; l++) run_line(l, 1'b0, 1'b0);

    run_frame(88, 1'b1, 2, 100, 50);   // crosshair (100,50), box queued mid-frame
    run_frame(88, 1'b0, 3, 10, 10);    // box (100,50), dot queued
    run_frame(36, 1'b0, int'($urandom_range(1, 3)), int'($urandom_range(0, 150)),
              int'($urandom_range(0, 40)));
    run_frame(60, 1'b0, int'($urandom_range(1, 3)), int'($urandom_range(0, 150)),
              int'($urandom_range(0, 3)));

    // csync stops: lock must drop once the line timeout expires.
    for (int s = 0; s < 400; s++) begin
      int c;
      c = LINE_CLKS + s;
      step(1'b1, 1'b1, -1, -1, (c == 300) || (c >= 330), c < 330, 1'b0);
    end
    for (int l = 0; l < 2; l++) run_line(l, 1'b0, 1'b0);
    run_frame(24, 1'b1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
